// File: rtl/game_pkg.sv
// Shared constants, cell codes, direction and FSM encodings for the game grid logic.
package game_pkg;

  localparam int GRID_W  = 10;
  localparam int GRID_H  = 10;
  localparam int RUN_LEN = 4;
  localparam int CELL_W  = 4;
  localparam int K_W     = $clog2(RUN_LEN);

  localparam logic [CELL_W-1:0] EMPTY    = 4'd0;
  localparam logic [CELL_W-1:0] CIRCLE   = 4'd1;
  localparam logic [CELL_W-1:0] TRIANGLE = 4'd2;

  localparam logic [1:0] DIR_H = 2'd0;
  localparam logic [1:0] DIR_V = 2'd1;
  localparam logic [1:0] DIR_D = 2'd2;
  localparam logic [1:0] DIR_A = 2'd3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_ISSUE   = 3'd2;
  localparam logic [2:0] ST_CMP     = 3'd3;
  localparam logic [2:0] ST_ADVANCE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef struct packed {
    logic [3:0] x_lo;
    logic [3:0] x_hi;
    logic [3:0] y_lo;
    logic [3:0] y_hi;
    logic       empty;
  } scan_range_t;

  // Line-start window that keeps every cell of a line inside the board.
  function automatic scan_range_t full_range(input logic [1:0] dir);
    scan_range_t r;
    r.x_lo  = (dir == DIR_A) ? 4'(RUN_LEN - 1) : 4'd0;
    r.x_hi  = (dir == DIR_V || dir == DIR_A) ? 4'(GRID_W - 1) : 4'(GRID_W - RUN_LEN);
    r.y_lo  = 4'd0;
    r.y_hi  = (dir == DIR_H) ? 4'(GRID_H - 1) : 4'(GRID_H - RUN_LEN);
    r.empty = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/win_line_addr_gen.sv
// Combinational cell address of the k-th cell of a line starting at (x, y) in direction dir.
module win_line_addr_gen
  import game_pkg::*;
(
  input  logic [3:0]     x,
  input  logic [3:0]     y,
  input  logic [1:0]     dir,
  input  logic [K_W-1:0] k,
  output logic [6:0]     addr
);

  logic [6:0] cx;
  logic [6:0] cy;
  logic [6:0] kk;

  always_comb begin
    kk = 7'(k);
    cx = {3'b000, x};
    cy = {3'b000, y};
    case (dir)
      DIR_H:   cx = cx + kk;
      DIR_V:   cy = cy + kk;
      DIR_D: begin
        cx = cx + kk;
        cy = cy + kk;
      end
      default: begin
        cx = cx - kk;
        cy = cy + kk;
      end
    endcase
    addr = cx + 7'(GRID_W) * cy;
  end

endmodule

// File: rtl/grid_win_scan_controller.sv
// Scans the grid for RUN_LEN-in-a-row of the latched player after each move.
// Define WIN_SCAN_LAST_MOVE_EN to restrict the scan to starts near last_x/last_y.
module grid_win_scan_controller
  import game_pkg::*;
(
  input  logic              clock_builtin_50MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic [CELL_W-1:0] player,
  input  logic [3:0]        last_x,
  input  logic [3:0]        last_y,
  output logic              cell_rd_en,
  output logic [6:0]        cell_addr,
  input  logic [CELL_W-1:0] cell_data,
  output logic              busy,
  output logic              done,
  output logic              win,
  output logic [1:0]        win_dir,
  output logic [3:0]        win_x,
  output logic [3:0]        win_y
);

  logic [2:0]        state_q, state_d;
  logic [1:0]        dir_q, dir_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [3:0]        x_q, x_d;
  logic [3:0]        y_q, y_d;
  logic [CELL_W-1:0] player_q, player_d;
  logic              win_q, win_d;
  logic [1:0]        win_dir_q, win_dir_d;
  logic [3:0]        win_x_q, win_x_d;
  logic [3:0]        win_y_q, win_y_d;

  scan_range_t rng [4];
  logic [2:0]  search_lo;
  logic        nxt_found;
  logic [1:0]  nxt_dir;
  logic [6:0]  line_addr;

`ifdef WIN_SCAN_LAST_MOVE_EN
  logic [3:0] last_x_q, last_x_d;
  logic [3:0] last_y_q, last_y_d;

  // Anti-diagonal lines run toward -x, so their starts sit at or right of the move.
  function automatic scan_range_t clamp_range(input scan_range_t r, input logic [1:0] dir,
                                              input logic [3:0] lx, input logic [3:0] ly);
    scan_range_t c;
    int xl, xh, yl, yh;
    xl = int'(r.x_lo);
    xh = int'(r.x_hi);
    yl = int'(r.y_lo);
    yh = int'(r.y_hi);
    if (dir == DIR_A) begin
      xl = (int'(lx) > xl) ? int'(lx) : xl;
      xh = (int'(lx) + RUN_LEN - 1 < xh) ? int'(lx) + RUN_LEN - 1 : xh;
    end else begin
      xl = (int'(lx) - (RUN_LEN - 1) > xl) ? int'(lx) - (RUN_LEN - 1) : xl;
      xh = (int'(lx) < xh) ? int'(lx) : xh;
    end
    yl = (int'(ly) - (RUN_LEN - 1) > yl) ? int'(ly) - (RUN_LEN - 1) : yl;
    yh = (int'(ly) < yh) ? int'(ly) : yh;
    c.x_lo  = 4'(xl);
    c.x_hi  = 4'(xh);
    c.y_lo  = 4'(yl);
    c.y_hi  = 4'(yh);
    c.empty = (xl > xh) || (yl > yh);
    return c;
  endfunction
`else
  logic unused_last;
  assign unused_last = ^{last_x, last_y};
`endif

  always_comb begin
    for (int d = 0; d < 4; d++) begin
      rng[d] = full_range(2'(d));
`ifdef WIN_SCAN_LAST_MOVE_EN
      rng[d] = clamp_range(rng[d], 2'(d), last_x_q, last_y_q);
`endif
    end
  end

  // Lowest non-empty direction at or after search_lo; SETUP searches from H.
  always_comb begin
    search_lo = (state_q == ST_SETUP) ? 3'd0 : ({1'b0, dir_q} + 3'd1);
    nxt_found = 1'b0;
    nxt_dir   = DIR_H;
    for (int d = 3; d >= 0; d--) begin
      if (3'(d) >= search_lo && !rng[d].empty) begin
        nxt_found = 1'b1;
        nxt_dir   = 2'(d);
      end
    end
  end

  win_line_addr_gen u_addr_gen (
    .x   (x_q),
    .y   (y_q),
    .dir (dir_q),
    .k   (k_q),
    .addr(line_addr)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    k_d       = k_q;
    x_d       = x_q;
    y_d       = y_q;
    player_d  = player_q;
    win_d     = win_q;
    win_dir_d = win_dir_q;
    win_x_d   = win_x_q;
    win_y_d   = win_y_q;
`ifdef WIN_SCAN_LAST_MOVE_EN
    last_x_d  = last_x_q;
    last_y_d  = last_y_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          player_d  = player;
`ifdef WIN_SCAN_LAST_MOVE_EN
          last_x_d  = last_x;
          last_y_d  = last_y;
`endif
          win_d     = 1'b0;
          win_dir_d = 2'd0;
          win_x_d   = 4'd0;
          win_y_d   = 4'd0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        k_d = '0;
        if (player_q == EMPTY || !nxt_found) begin
          state_d = ST_DONE;
        end else begin
          dir_d   = nxt_dir;
          x_d     = rng[nxt_dir].x_lo;
          y_d     = rng[nxt_dir].y_lo;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_CMP;
      ST_CMP: begin
        if (cell_data != player_q) begin
          state_d = ST_ADVANCE;
        end else if (k_q != K_W'(RUN_LEN - 1)) begin
          k_d     = k_q + K_W'(1);
          state_d = ST_ISSUE;
        end else begin
          win_d     = 1'b1;
          win_dir_d = dir_q;
          win_x_d   = x_q;
          win_y_d   = y_q;
          state_d   = ST_DONE;
        end
      end
      ST_ADVANCE: begin
        k_d     = '0;
        state_d = ST_ISSUE;
        if (x_q < rng[dir_q].x_hi) begin
          x_d = x_q + 4'd1;
        end else if (y_q < rng[dir_q].y_hi) begin
          x_d = rng[dir_q].x_lo;
          y_d = y_q + 4'd1;
        end else if (nxt_found) begin
          dir_d = nxt_dir;
          x_d   = rng[nxt_dir].x_lo;
          y_d   = rng[nxt_dir].y_lo;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_builtin_50MHZ or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_H;
      k_q       <= '0;
      x_q       <= 4'd0;
      y_q       <= 4'd0;
      player_q  <= EMPTY;
      win_q     <= 1'b0;
      win_dir_q <= 2'd0;
      win_x_q   <= 4'd0;
      win_y_q   <= 4'd0;
`ifdef WIN_SCAN_LAST_MOVE_EN
      last_x_q  <= 4'd0;
      last_y_q  <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      k_q       <= k_d;
      x_q       <= x_d;
      y_q       <= y_d;
      player_q  <= player_d;
      win_q     <= win_d;
      win_dir_q <= win_dir_d;
      win_x_q   <= win_x_d;
      win_y_q   <= win_y_d;
`ifdef WIN_SCAN_LAST_MOVE_EN
      last_x_q  <= last_x_d;
      last_y_q  <= last_y_d;
`endif
    end
  end

  assign busy       = (state_q == ST_SETUP) || (state_q == ST_ISSUE) ||
                      (state_q == ST_CMP) || (state_q == ST_ADVANCE);
  assign done       = (state_q == ST_DONE);
  assign cell_rd_en = (state_q == ST_ISSUE);
  assign cell_addr  = cell_rd_en ? line_addr : 7'd0;
  assign win        = win_q;
  assign win_dir    = win_dir_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;

endmodule

// File: tb/tb_grid_win_scan_controller.sv
// Randomized self-checking bench: a grid memory with 1-cycle read latency and a scan-order reference model.
module tb_grid_win_scan_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] player = 4'd0;
  logic [3:0] last_x = 4'd0;
  logic [3:0] last_y = 4'd0;
  logic       cell_rd_en;
  logic [6:0] cell_addr;
  logic [3:0] cell_data = 4'd0;
  logic       busy, done, win;
  logic [1:0] win_dir;
  logic [3:0] win_x, win_y;

  grid_win_scan_controller dut (
    .clock_builtin_50MHZ(clk),
    .reset     (reset),
    .start     (start),
    .player    (player),
    .last_x    (last_x),
    .last_y    (last_y),
    .cell_rd_en(cell_rd_en),
    .cell_addr (cell_addr),
    .cell_data (cell_data),
    .busy      (busy),
    .done      (done),
    .win       (win),
    .win_dir   (win_dir),
    .win_x     (win_x),
    .win_y     (win_y)
  );

  always #10 clk = ~clk;

  logic [3:0] grid [100];
  int exp_addr [$];
  int passed = 0;
  int total  = 0;

  typedef struct {
    int win;
    int dir;
    int x;
    int y;
    int cycles;
  } res_t;

  always @(posedge clk)
    if (cell_rd_en) cell_data <= (cell_addr < 7'd100) ? grid[cell_addr] : 4'hF;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Every read strobe must hit the next cell the reference scan would visit.
  always @(negedge clk) begin
    if (!reset && cell_rd_en) begin
      if (exp_addr.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_addr", int'(cell_addr), exp_addr.pop_front());
    end
  end

  function automatic void clear_grid();
    for (int i = 0; i < 100; i++) grid[i] = 4'd0;
  endfunction

  function automatic void put(input int x, input int y, input int v);
    grid[x + 10 * y] = 4'(v);
  endfunction

  // Walks line starts in H,V,D,A order, y outer / x inner, stopping at the first mismatch.
  function automatic void model(input int p, input int lx, input int ly, output res_t r);
    int dx, dy, xlo, xhi, ylo, yhi, m;
    r = '{0, 0, 0, 0, 2};
    exp_addr.delete();
    if (p == 0) return;
    for (int d = 0; d < 4; d++) begin
      dx  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      dy  = (d == 0) ? 0 : 1;
      xlo = (d == 3) ? 3 : 0;
      xhi = (d == 1 || d == 3) ? 9 : 6;
      ylo = 0;
      yhi = (d == 0) ? 9 : 6;
`ifdef WIN_SCAN_LAST_MOVE_EN
      if (d == 3) begin
        if (lx > xlo) xlo = lx;
        if (lx + 3 < xhi) xhi = lx + 3;
      end else begin
        if (lx - 3 > xlo) xlo = lx - 3;
        if (lx < xhi) xhi = lx;
      end
      if (ly - 3 > ylo) ylo = ly - 3;
      if (ly < yhi) yhi = ly;
`endif
      for (int y = ylo; y <= yhi; y++) begin
        for (int x = xlo; x <= xhi; x++) begin
          m = 0;
          while (m < 4) begin
            exp_addr.push_back((x + m * dx) + 10 * (y + m * dy));
            if (int'(grid[(x + m * dx) + 10 * (y + m * dy)]) != p) break;
            m++;
          end
          if (m == 4) begin
            r.win = 1; r.dir = d; r.x = x; r.y = y;
            r.cycles += 8;
            return;
          end
          r.cycles += 2 * (m + 1) + 1;
        end
      end
    end
  endfunction

  task automatic run_scan(input string tag, input int p, input int lx, input int ly,
                          input int extra_at, output res_t got, output int lat);
    res_t e;
    int n, busy_err;
    bit seen;
    model(p, lx, ly, e);
    got = '{0, 0, 0, 0, 0};
    @(negedge clk);
    player = 4'(p); last_x = 4'(lx); last_y = 4'(ly); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1; busy_err = 0; seen = 0;
    while (n < 4000) begin
      if (n == extra_at) begin
        start  = 1'b1;
        player = (p == 1) ? 4'd2 : 4'd1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1;
        break;
      end
      if (!busy) busy_err++;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    lat = n;
    if (!seen) begin
      check({tag, "_done_timeout"}, 0, 1);
      exp_addr.delete();
      return;
    end
    got = '{int'(win), int'(win_dir), int'(win_x), int'(win_y), n};
    check({tag, "_latency"}, n, e.cycles);
    check({tag, "_busy_window"}, busy_err, 0);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    check({tag, "_win"}, int'(win), e.win);
    if (e.win != 0) begin
      check({tag, "_dir"}, int'(win_dir), e.dir);
      check({tag, "_x"}, int'(win_x), e.x);
      check({tag, "_y"}, int'(win_y), e.y);
    end
    check({tag, "_reads_left"}, exp_addr.size(), 0);
    exp_addr.delete();
    repeat (3) begin
      @(negedge clk);
      check({tag, "_done_single"}, int'(done), 0);
    end
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_win_held"}, int'(win), e.win);
  endtask

  initial begin
    res_t r;
    int lat, dens, dcnt, bcnt;

    clear_grid();
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_win", int'(win), 0);
    check("rst_rd_en", int'(cell_rd_en), 0);
    check("rst_addr", int'(cell_addr), 0);
    check("rst_win_dir_xy", int'({win_dir, win_x, win_y}), 0);
    reset = 1'b0;

    // Empty grid: nothing matches, full scan of 238 starts at 3 cycles each.
    run_scan("empty", 2, 0, 0, 0, r, lat);
    check("empty_win_lit", r.win, 0);
`ifdef WIN_SCAN_LAST_MOVE_EN
    check("empty_lat_lit", lat, 14);
`else
    check("empty_lat_lit", lat, 716);
`endif

    clear_grid();
    for (int i = 3; i <= 6; i++) put(i, 5, 2);
    run_scan("horiz", 2, 6, 5, 0, r, lat);
    check("horiz_lit", r.win * 1000 + r.dir * 100 + r.x * 10 + r.y, 1035);
    run_scan("horiz_restart", 2, 6, 5, 3, r, lat);
    check("horiz_restart_lit", r.win * 1000 + r.dir * 100 + r.x * 10 + r.y, 1035);

    clear_grid();
    for (int i = 6; i <= 9; i++) put(9, i, 1);
    run_scan("vert", 1, 9, 9, 0, r, lat);
    check("vert_lit", r.win * 1000 + r.dir * 100 + r.x * 10 + r.y, 1196);
    run_scan("vert_other", 2, 9, 9, 0, r, lat);
    check("vert_other_lit", r.win, 0);

    clear_grid();
    for (int i = 0; i < 4; i++) put(6 - i, i, 2);
    run_scan("anti", 2, 3, 3, 0, r, lat);
    check("anti_lit", r.win * 1000 + r.dir * 100 + r.x * 10 + r.y, 1360);

    clear_grid();
    for (int i = 0; i <= 4; i++) put(i, 0, 2);
    run_scan("five", 2, 0, 0, 0, r, lat);
    check("five_lit", r.win * 1000 + r.dir * 100 + r.x * 10 + r.y, 1000);

    clear_grid();
    for (int i = 2; i <= 4; i++) put(i, 2, 2);
    put(5, 2, 1);
    run_scan("three_one", 2, 5, 2, 0, r, lat);
    check("three_one_lit", r.win, 0);
    run_scan("player_empty", 0, 5, 2, 0, r, lat);
    check("player_empty_lat_lit", lat, 2);

    for (int it = 0; it < 25; it++) begin
      clear_grid();
      dens = $urandom_range(2, 35);
      for (int i = 0; i < 100; i++)
        grid[i] = ($urandom_range(0, 99) < dens) ? 4'($urandom_range(1, 2)) : 4'd0;
      run_scan("rand", $urandom_range(1, 2), $urandom_range(0, 9), $urandom_range(0, 9),
               (it % 5 == 0) ? 4 : 0, r, lat);
    end

    // Reset in the middle of a full scan must abort with no done pulse.
    clear_grid();
    model(1, 0, 0, r);
    @(negedge clk);
    player = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    exp_addr.delete();
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_win", int'(win), 0);
    check("midrst_rd_en", int'(cell_rd_en), 0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0; bcnt = 0;
    repeat (800) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    check("midrst_no_done", dcnt, 0);
    check("midrst_no_busy", bcnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
